// File: rtl/adpll_ctrl_pkg.sv
// Shared types and defaults for the ADPLL lock controller.
package adpll_ctrl_pkg;

  // Controller states; the encoding is visible on state_o.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_COARSE = 3'd2,
    ST_FINE   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  // Loop gain selection driven to the ADPLL.
  localparam logic GAIN_COARSE = 1'b0;
  localparam logic GAIN_FINE   = 1'b1;

  // Default tuning of the lock sequence.
  localparam int DEF_SETTLE_CYCLES = 64;
  localparam int DEF_COARSE_THRESH = 16;
  localparam int DEF_LOCK_THRESH   = 4;
  localparam int DEF_LOCK_COUNT    = 16;
  localparam int DEF_UNLOCK_THRESH = 16;
  localparam int DEF_UNLOCK_COUNT  = 4;
  localparam int DEF_TIMEOUT       = 4096;

  // The window counter serves both lock and unlock qualification, so it is
  // sized for the larger of the two targets.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/error_magnitude.sv
// Saturating absolute value of the signed 8-bit phase error.
// -128 has no positive 8-bit twin, so it is clamped to 127.
module error_magnitude (
  input  logic [7:0] error_i,
  output logic [6:0] mag_o
);

  logic [7:0] abs_val;

  // Two's-complement negate negative errors, then clamp the lone -128 case.
  always_comb begin
    abs_val = error_i[7] ? (~error_i + 8'd1) : error_i;
    mag_o   = abs_val[7] ? 7'h7f : abs_val[6:0];
  end

endmodule

// File: rtl/adpll_lock_controller.sv
// Lock sequencing FSM for an all-digital PLL: settle, coarse acquisition,
// fine acquisition, locked monitoring and timeout fault.
module adpll_lock_controller
  import adpll_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int COARSE_THRESH = DEF_COARSE_THRESH,
  parameter int LOCK_THRESH   = DEF_LOCK_THRESH,
  parameter int LOCK_COUNT    = DEF_LOCK_COUNT,
  parameter int UNLOCK_THRESH = DEF_UNLOCK_THRESH,
  parameter int UNLOCK_COUNT  = DEF_UNLOCK_COUNT,
  parameter int TIMEOUT       = DEF_TIMEOUT
) (
  input  logic       fpga_clk_i,
  input  logic       reset_n_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic [7:0] error_i,
  input  logic       error_valid_i,
  output logic       adpll_enable_o,
  output logic       gain_sel_o,
  output logic       locked_o,
  output logic       lock_lost_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int WIN_MAX  = max_int(LOCK_COUNT, UNLOCK_COUNT);
  localparam int WIN_W    = $clog2(WIN_MAX + 1);
  localparam int TMO_W    = $clog2(TIMEOUT + 1);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_SAT  = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [WIN_W-1:0]    WIN_SAT     = WIN_W'(WIN_MAX);
  localparam logic [WIN_W-1:0]    WIN_LOCK    = WIN_W'(LOCK_COUNT);
  localparam logic [WIN_W-1:0]    WIN_UNLOCK  = WIN_W'(UNLOCK_COUNT);
  localparam logic [TMO_W-1:0]    TMO_SAT     = TMO_W'(TIMEOUT);
  localparam logic [6:0]          COARSE_LIM  = 7'(COARSE_THRESH);
  localparam logic [6:0]          LOCK_LIM    = 7'(LOCK_THRESH);
  localparam logic [6:0]          UNLOCK_LIM  = 7'(UNLOCK_THRESH);

  state_e               state_q, state_d;
  logic [SETTLE_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic                 adpll_enable_q, adpll_enable_d;
  logic                 gain_sel_q, gain_sel_d;
  logic                 locked_q, locked_d;
  logic                 lock_lost_q, lock_lost_d;
  logic                 fault_q, fault_d;

  logic [6:0]           mag;
  logic [SETTLE_W-1:0]  settle_inc;
  logic [WIN_W-1:0]     win_inc;
  logic [TMO_W-1:0]     tmo_inc;

  error_magnitude u_error_magnitude (
    .error_i (error_i),
    .mag_o   (mag)
  );

  // Saturating increments; transitions fire on reaching the target, so
  // saturation only guards against wrap if a count were ever left running.
  always_comb begin
    settle_inc = (settle_cnt_q == SETTLE_SAT) ? settle_cnt_q : settle_cnt_q + SETTLE_W'(1);
    win_inc    = (win_cnt_q == WIN_SAT)       ? win_cnt_q    : win_cnt_q + WIN_W'(1);
    tmo_inc    = (tmo_cnt_q == TMO_SAT)       ? tmo_cnt_q    : tmo_cnt_q + TMO_W'(1);
  end

  // Next-state, counter updates and registered-output precompute.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    win_cnt_d    = win_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    lock_lost_d  = 1'b0;

    if (stop_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d      = ST_SETTLE;
            settle_cnt_d = '0;
            win_cnt_d    = '0;
            tmo_cnt_d    = '0;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d = ST_COARSE;
          end else begin
            settle_cnt_d = settle_inc;
          end
        end

        ST_COARSE: begin
          if (error_valid_i) begin
            tmo_cnt_d = tmo_inc;
            if (tmo_inc == TMO_SAT) begin
              state_d = ST_FAULT;
            end else if (mag <= COARSE_LIM) begin
              if (win_inc == WIN_LOCK) begin
                state_d   = ST_FINE;
                win_cnt_d = '0;
              end else begin
                win_cnt_d = win_inc;
              end
            end else begin
              win_cnt_d = '0;
            end
          end
        end

        ST_FINE: begin
          if (error_valid_i) begin
            tmo_cnt_d = tmo_inc;
            if (tmo_inc == TMO_SAT) begin
              state_d = ST_FAULT;
            end else if (mag > COARSE_LIM) begin
              state_d   = ST_COARSE;
              win_cnt_d = '0;
            end else if (mag <= LOCK_LIM) begin
              if (win_inc == WIN_LOCK) begin
                state_d   = ST_LOCKED;
                win_cnt_d = '0;
                tmo_cnt_d = '0;
              end else begin
                win_cnt_d = win_inc;
              end
            end else begin
              win_cnt_d = '0;
            end
          end
        end

        ST_LOCKED: begin
          if (error_valid_i) begin
            if (mag > UNLOCK_LIM) begin
              if (win_inc == WIN_UNLOCK) begin
                state_d      = ST_COARSE;
                lock_lost_d  = 1'b1;
                settle_cnt_d = '0;
                win_cnt_d    = '0;
                tmo_cnt_d    = '0;
              end else begin
                win_cnt_d = win_inc;
              end
            end else begin
              win_cnt_d = '0;
            end
          end
        end

        ST_FAULT: begin
          state_d = ST_FAULT;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    adpll_enable_d = (state_d == ST_SETTLE) || (state_d == ST_COARSE) ||
                     (state_d == ST_FINE)   || (state_d == ST_LOCKED);
    gain_sel_d     = ((state_d == ST_FINE) || (state_d == ST_LOCKED)) ? GAIN_FINE : GAIN_COARSE;
    locked_d       = (state_d == ST_LOCKED);
    fault_d        = (state_d == ST_FAULT);
  end

  // State, counters and outputs; reset clears everything with no pulse.
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q        <= ST_IDLE;
      settle_cnt_q   <= '0;
      win_cnt_q      <= '0;
      tmo_cnt_q      <= '0;
      adpll_enable_q <= 1'b0;
      gain_sel_q     <= 1'b0;
      locked_q       <= 1'b0;
      lock_lost_q    <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      settle_cnt_q   <= settle_cnt_d;
      win_cnt_q      <= win_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      adpll_enable_q <= adpll_enable_d;
      gain_sel_q     <= gain_sel_d;
      locked_q       <= locked_d;
      lock_lost_q    <= lock_lost_d;
      fault_q        <= fault_d;
    end
  end

  assign adpll_enable_o = adpll_enable_q;
  assign gain_sel_o     = gain_sel_q;
  assign locked_o       = locked_q;
  assign lock_lost_o    = lock_lost_q;
  assign fault_o        = fault_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_adpll_lock_controller.sv
// Directed bench for adpll_lock_controller with default parameters.
module tb_adpll_lock_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] err = 8'd0;
  logic       err_valid = 1'b0;
  logic       enable, gain, locked, lost, fault;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;
  int lost_pulses = 0;

  adpll_lock_controller dut (
    .fpga_clk_i     (clk),
    .reset_n_i      (rst_n),
    .start_i        (start),
    .stop_i         (stop),
    .error_i        (err),
    .error_valid_i  (err_valid),
    .adpll_enable_o (enable),
    .gain_sel_o     (gain),
    .locked_o       (locked),
    .lock_lost_o    (lost),
    .fault_o        (fault),
    .state_o        (state)
  );

  always #5 clk = ~clk;

  // Count every cycle on which lock_lost_o is seen high.
  always @(negedge clk) if (lost) lost_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One error sample; returns at the negedge after the sampling edge.
  task automatic sample(input logic [7:0] e);
    @(negedge clk);
    err = e;
    err_valid = 1'b1;
    @(negedge clk);
    err_valid = 1'b0;
  endtask

  task automatic samples(input logic [7:0] e, input int n);
    for (int i = 0; i < n; i++) sample(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #12;
    check("rst_state", state, 0);
    check("rst_enable", enable, 0);
    check("rst_fault", fault, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // stop and start together in IDLE: stay IDLE
    start = 1'b1;
    stop = 1'b1;
    cycles(3);
    check("idle_stop_start_state", state, 0);
    check("idle_stop_start_en", enable, 0);
    stop = 1'b0;
    @(negedge clk);
    check("idle_to_settle", state, 1);
    cycles(5);
    start = 1'b0;
    stop = 1'b1;
    @(negedge clk);
    check("settle_stop_state", state, 0);
    check("settle_stop_en", enable, 0);
    stop = 1'b0;

    // Start, settle for exactly 64 cycles
    start = 1'b1;
    @(negedge clk);
    check("settle_state", state, 1);
    check("settle_en", enable, 1);
    check("settle_gain", gain, 0);
    cycles(63);
    check("settle_last_cycle", state, 1);
    cycles(1);
    check("coarse_entry", state, 2);
    check("coarse_gain", gain, 0);

    // +3 samples: FINE on 16th, LOCKED on 32nd
    samples(8'd3, 15);
    check("coarse_15", state, 2);
    sample(8'd3);
    check("fine_16", state, 3);
    check("fine_gain", gain, 1);
    samples(8'd3, 15);
    check("fine_31_state", state, 3);
    check("fine_31_locked", locked, 0);
    sample(8'd3);
    check("locked_32_state", state, 4);
    check("locked_32_locked", locked, 1);

    // LOCKED: -20 x3, +2, -20 x4; start drop has no effect
    start = 1'b0;
    samples(8'hEC, 3);
    check("burst1_state", state, 4);
    check("burst1_pulses", lost_pulses, 0);
    sample(8'd2);
    samples(8'hEC, 3);
    check("burst2_3_state", state, 4);
    check("burst2_3_lost", lost, 0);
    sample(8'hEC);
    check("unlock_lost", lost, 1);
    check("unlock_state", state, 2);
    check("unlock_locked", locked, 0);
    cycles(1);
    check("unlock_pulse_end", lost, 0);
    check("unlock_pulse_count", lost_pulses, 1);

    // FINE window boundaries
    samples(8'd3, 16);
    check("refine_state", state, 3);
    sample(8'd16);
    check("fine_mag16_stays", state, 3);
    sample(8'hEF);
    check("fine_m17_state", state, 2);
    check("fine_m17_gain", gain, 0);
    samples(8'd3, 16);
    check("refine2_state", state, 3);
    sample(8'h80);
    check("fine_m128_state", state, 2);

    // Async reset while LOCKED
    samples(8'd3, 32);
    check("relock_state", state, 4);
    check("relock_locked", locked, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_state", state, 0);
    check("async_enable", enable, 0);
    check("async_gain", gain, 0);
    check("async_locked", locked, 0);
    check("async_lost", lost, 0);
    check("async_fault", fault, 0);
    cycles(2);
    check("async_no_pulse", lost_pulses, 1);

    // Timeout with constant +40
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("tmo_settle", state, 1);
    cycles(64);
    check("tmo_coarse", state, 2);
    samples(8'd40, 4095);
    check("tmo_4095_state", state, 2);
    check("tmo_4095_fault", fault, 0);
    sample(8'd40);
    check("tmo_4096_state", state, 5);
    check("tmo_4096_fault", fault, 1);
    check("tmo_4096_enable", enable, 0);
    sample(8'd3);
    check("fault_holds", state, 5);
    stop = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("fault_stop_state", state, 0);
    check("fault_stop_fault", fault, 0);
    stop = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
